// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount accumulator.
//   state_e  : frame controller states (idle, accumulating, holding a result)
//   ACT_*    : ternary activation encodings driven on out_act
package popcount_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;

endpackage

// File: rtl/popcount_core.sv
// Combinational population count of a W-bit vector.
//   vec   : input vector
//   cnt_c : number of set bits in vec, $clog2(W+1) bits wide
module popcount_core #(
  parameter int unsigned W = 21
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   cnt_c
);

  localparam int unsigned CW = $clog2(W + 1);

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < W; i++) begin
      cnt_c = cnt_c + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/popcount_acc.sv
// Frame accumulator of signed ternary popcounts with a thresholded activation.
// Each accepted beat adds popcount(in_pos) - popcount(in_neg); a frame closes on
// in_last or on the BEATS-th beat, after which the result is held until out_ready.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : beat handshake (in_ready is low while a result is held)
//   in_pos, in_neg    : +1 / -1 weight hit vectors; in_last marks the final beat
//   thr               : unsigned threshold, captured on the closing beat
//   out_valid/out_ready : result handshake
//   out_sum           : signed frame sum; out_act: ternary activation
//   out_overrun       : frame was closed by the BEATS limit without in_last
// Build option: define POPCNT_TRUNC_LSB_EN to clear bit 0 of each per-beat count.
module popcount_acc
  import popcount_pkg::*;
#(
  parameter int unsigned W     = 21,
  parameter int unsigned BEATS = 4,
  parameter int unsigned SW    = $clog2(W * BEATS + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_pos,
  input  logic [W-1:0]         in_neg,
  input  logic                 in_last,
  input  logic [SW-2:0]        thr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [SW-1:0] out_sum,
  output logic [1:0]           out_act,
  output logic                 out_overrun
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned BW = $clog2(BEATS + 1);

  state_e               state_q, state_d;
  logic signed [SW-1:0] acc_q, acc_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [SW-1:0] out_sum_q, out_sum_d;
  logic [1:0]           out_act_q, out_act_d;
  logic                 out_overrun_q, out_overrun_d;

  logic [CW-1:0]        pos_cnt_c, neg_cnt_c;
  logic [CW-1:0]        pos_eff_c, neg_eff_c;
  logic signed [SW-1:0] beat_sum_c;
  logic signed [SW-1:0] thr_s_c;
  logic [1:0]           act_c;
  logic                 accept_c, at_limit_c, close_c;

  popcount_core #(.W(W)) u_pos_cnt (.vec(in_pos), .cnt_c(pos_cnt_c));
  popcount_core #(.W(W)) u_neg_cnt (.vec(in_neg), .cnt_c(neg_cnt_c));

  // Per-beat counts fed to the accumulator, optionally with the LSB dropped.
  always_comb begin
`ifdef POPCNT_TRUNC_LSB_EN
    pos_eff_c = pos_cnt_c & ~CW'(1);
    neg_eff_c = neg_cnt_c & ~CW'(1);
`else
    pos_eff_c = pos_cnt_c;
    neg_eff_c = neg_cnt_c;
`endif
  end

  // Running sum including the current beat, and its activation against thr.
  always_comb begin
    beat_sum_c = acc_q + $signed(SW'(pos_eff_c)) - $signed(SW'(neg_eff_c));
    thr_s_c    = $signed({1'b0, thr});
    if (beat_sum_c > thr_s_c) begin
      act_c = ACT_POS;
    end else if (beat_sum_c < -thr_s_c) begin
      act_c = ACT_NEG;
    end else begin
      act_c = ACT_ZERO;
    end
  end

  assign accept_c   = in_valid && in_ready_q;
  assign at_limit_c = (beat_q == BW'(BEATS - 1));
  assign close_c    = in_last || at_limit_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    beat_d        = beat_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_act_d     = out_act_q;
    out_overrun_d = out_overrun_q;

    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (accept_c) begin
          if (close_c) begin
            state_d       = ST_HOLD;
            acc_d         = beat_sum_c;
            beat_d        = '0;
            out_valid_d   = 1'b1;
            out_sum_d     = beat_sum_c;
            out_act_d     = act_c;
            out_overrun_d = !in_last;
          end else begin
            state_d = ST_ACC;
            acc_d   = beat_sum_c;
            beat_d  = beat_q + BW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          acc_d       = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        acc_d       = '0;
        beat_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = !out_valid_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      beat_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_act_q     <= ACT_ZERO;
      out_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      beat_q        <= beat_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_act_q     <= out_act_d;
      out_overrun_q <= out_overrun_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_act     = out_act_q;
  assign out_overrun = out_overrun_q;

endmodule

// File: tb/tb_popcount_acc.sv
// Directed bench for popcount_acc with a frame-level reference model.
module tb_popcount_acc;

  localparam int unsigned W     = 21;
  localparam int unsigned BEATS = 4;
  localparam int unsigned SW    = $clog2(W * BEATS + 1) + 1;

`ifdef POPCNT_TRUNC_LSB_EN
  localparam int E_FULL = 20;
  localparam int E_FOUR = 0;
  localparam int E_ACT4 = 0;
  localparam int E_SEV  = 2;
`else
  localparam int E_FULL = 21;
  localparam int E_FOUR = 4;
  localparam int E_ACT4 = 1;
  localparam int E_SEV  = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_pos;
  logic [W-1:0]         in_neg;
  logic                 in_last;
  logic [SW-2:0]        thr;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [SW-1:0] out_sum;
  logic [1:0]           out_act;
  logic                 out_overrun;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state.
  bit m_valid = 1'b0;
  int m_acc   = 0;
  int m_beats = 0;
  int m_sum   = 0;
  int m_act   = 0;
  int m_ovr   = 0;

  popcount_acc #(.W(W), .BEATS(BEATS), .SW(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pos     (in_pos),
    .in_neg     (in_neg),
    .in_last    (in_last),
    .thr        (thr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_act    (out_act),
    .out_overrun(out_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt(input logic [W-1:0] v);
    int c;
    c = $countones(v);
`ifdef POPCNT_TRUNC_LSB_EN
    c = c & ~1;
`endif
    return c;
  endfunction

  // Frame-level model: sums counts per frame and publishes a result on close.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_acc   = 0;
      m_beats = 0;
      m_sum   = 0;
      m_act   = 0;
      m_ovr   = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      m_acc   = m_acc + cnt(in_pos) - cnt(in_neg);
      m_beats = m_beats + 1;
      if (in_last || m_beats == BEATS) begin
        m_sum   = m_acc;
        m_act   = (m_acc > int'(thr)) ? 1 : ((m_acc < -int'(thr)) ? 3 : 0);
        m_ovr   = (!in_last) ? 1 : 0;
        m_valid = 1'b1;
        m_acc   = 0;
        m_beats = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid));
      if (m_valid) begin
        chk("model_sum", 32'($signed(out_sum)), m_sum);
        chk("model_act", 32'(out_act), m_act);
        chk("model_ovr", 32'(out_overrun), m_ovr);
      end
    end
  end

  task automatic beat(input logic [W-1:0] p, input logic [W-1:0] n, input logic l);
    in_valid = 1'b1;
    in_pos   = p;
    in_neg   = n;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("rel_valid", 32'(out_valid), 0);
    chk("rel_ready", 32'(in_ready), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_neg    = '0;
    in_last   = 1'b0;
    thr       = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_sum", 32'($signed(out_sum)), 0);
    chk("rst_act", 32'(out_act), 0);
    chk("rst_ovr", 32'(out_overrun), 0);
    chk_en = 1'b1;

    // Single full beat.
    thr = 7'd5;
    beat(21'h1FFFFF, 21'h0, 1'b1);
    chk("full_valid", 32'(out_valid), 1);
    chk("full_sum", 32'($signed(out_sum)), E_FULL);
    chk("full_act", 32'(out_act), 1);
    chk("full_ovr", 32'(out_overrun), 0);
    release_out();

    // Two negative beats, threshold on each side of the boundary.
    thr = 7'd4;
    beat(21'h7, 21'h1F, 1'b0);
    beat(21'h7, 21'h1F, 1'b1);
    chk("neg4_sum", 32'($signed(out_sum)), -4);
    chk("neg4_act", 32'(out_act), 0);
    release_out();
    thr = 7'd3;
    beat(21'h7, 21'h1F, 1'b0);
    beat(21'h7, 21'h1F, 1'b1);
    chk("neg3_sum", 32'($signed(out_sum)), -4);
    chk("neg3_act", 32'(out_act), 3);
    release_out();

    // Limit close without in_last, then hold under back-pressure.
    thr = 7'd0;
    for (int i = 0; i < 3; i++) beat(21'h1, 21'h0, 1'b0);
    chk("lim_pre_valid", 32'(out_valid), 0);
    beat(21'h1, 21'h0, 1'b0);
    chk("lim_valid", 32'(out_valid), 1);
    chk("lim_sum", 32'($signed(out_sum)), E_FOUR);
    chk("lim_act", 32'(out_act), E_ACT4);
    chk("lim_ovr", 32'(out_overrun), 1);
    chk("lim_ready", 32'(in_ready), 0);
    in_valid = 1'b1;
    in_pos   = 21'h1;
    thr      = 7'd9;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hold_sum", 32'($signed(out_sum)), E_FOUR);
    chk("hold_act", 32'(out_act), E_ACT4);
    chk("hold_ovr", 32'(out_overrun), 1);
    chk("hold_ready", 32'(in_ready), 0);
    release_out();

    // Reset mid-frame discards the partial sum.
    thr = 7'd0;
    beat(21'hFF, 21'h0, 1'b0);
    beat(21'hFF, 21'h0, 1'b0);
    do_reset();
    chk("midrst_ready", 32'(in_ready), 1);
    beat(21'h3, 21'h0, 1'b1);
    chk("midrst_sum", 32'($signed(out_sum)), 2);
    release_out();

    // Reset while holding drops the result.
    beat(21'h3, 21'h0, 1'b1);
    chk("hrst_pre", 32'(out_valid), 1);
    do_reset();
    chk("hrst_valid", 32'(out_valid), 0);
    chk("hrst_sum", 32'($signed(out_sum)), 0);

    // Reset wins over a simultaneous accept.
    in_valid = 1'b1;
    in_pos   = 21'h3;
    in_last  = 1'b1;
    do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("rstpri_valid", 32'(out_valid), 0);

    // Build-dependent truncation cases.
    beat(21'h7, 21'h1, 1'b1);
    chk("trunc_a_sum", 32'($signed(out_sum)), 2);
    release_out();
    beat(21'h7, 21'h0, 1'b1);
    chk("trunc_b_sum", 32'($signed(out_sum)), E_SEV);
    release_out();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_acc.md
POPCOUNT_ACC -- requirements
Module: popcount_acc

Interface
REQ-001 Parameter W, default 21: bits per input vector.
REQ-002 Parameter BEATS, default 4: max beats per frame.
REQ-003 Parameter SW, default $clog2(W*BEATS+1)+1: signed sum width.
REQ-004 Ports SHALL be, clock and reset first: clk  in  1  clock; rst  in  1  reset.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 in_valid  in  1  beat valid; in_ready  out  1  beat accepted when both high.
REQ-007 in_pos  in  W  +1 weight hits; in_neg  in  W  -1 weight hits; in_last  in  1  final beat.
REQ-008 thr  in  SW-1  unsigned activation threshold, sampled when out_valid rises.
REQ-009 out_valid  out  1; out_ready  in  1; out_sum  out  SW  signed frame sum.
REQ-010 out_act  out  2  ternary activation; out_overrun  out  1  frame closed by BEATS limit.

Function
REQ-011 Beat accepted iff in_valid && in_ready; in_ready SHALL equal !out_valid.
REQ-012 On accept: acc <= acc + popcount(in_pos) - popcount(in_neg). Equal bits set in both vectors cancel.
REQ-013 Beat counter SHALL increment per accept and clear at frame close.
REQ-014 Frame closes on an accepted beat with in_last=1, or on the BEATS-th accepted beat.
REQ-015 out_overrun=1 only when close is by the limit with in_last=0.
REQ-016 States IDLE (acc=0), ACC (>=1 beat), HOLD (out_valid=1).
REQ-017 Transitions: IDLE->ACC on accept without close. IDLE/ACC->HOLD on closing accept. HOLD->IDLE on out_ready.
REQ-018 Latency: out_valid SHALL assert the cycle after the closing accept; out_sum includes that beat.
REQ-019 out_act: 2'b01 if out_sum > thr, 2'b11 if out_sum < -thr, else 2'b00.
REQ-020 out_act uses no other encodings.
REQ-021 out_sum, out_act and out_overrun SHALL hold stable while out_valid && !out_ready.
REQ-022 In HOLD no beat is accepted. The acc clear and IDLE entry happen on the out handshake cycle.
REQ-023 Arithmetic SHALL be in SW bits signed. No overflow occurs for any W*BEATS by construction.

Reset
REQ-024 rst SHALL force IDLE, acc=0, beat counter=0, out_valid=0, out_sum=0, out_act=2'b00, out_overrun=0.
REQ-025 in_ready SHALL be 1 in the cycle after reset.
REQ-026 rst mid-frame SHALL discard partial accumulation. rst in HOLD SHALL drop the pending result.
REQ-027 rst has priority over a simultaneous accept or out handshake.

Configuration
REQ-028 Macro POPCNT_TRUNC_LSB_EN selects approximate per-beat counts.
REQ-029 Defined: each per-beat popcount (pos and neg) SHALL have bit 0 forced to 0 before accumulation.
REQ-030 Undefined: exact popcounts are used. Interface and timing are identical in both builds.

Structure
REQ-031 Package popcount_pkg SHALL hold the state enum and the out_act encoding constants (ACT_POS, ACT_NEG, ACT_ZERO).
REQ-032 Sub-module popcount_core (parameter W, combinational, W-bit in, $clog2(W+1)-bit out) SHALL be instantiated twice, once for pos and once for neg.
REQ-033 The POPCNT_TRUNC_LSB_EN truncation SHALL be applied in popcount_acc, not in popcount_core.

Verification (W=21, BEATS=4)
REQ-034 Single beat, pos=0x1FFFFF, neg=0, last, thr=5 -> next cycle out_valid=1, out_sum=21, act=01, overrun=0.
REQ-035 Two beats, each pos=0x7, neg=0x1F, last on beat 2, thr=4 -> out_sum=-4, act=00. Rerun with thr=3 -> act=11.
REQ-036 Four beats, pos=0x1, no last -> out_valid after beat 4, out_sum=4, overrun=1, in_ready=0.
REQ-037 out_ready low 3 cycles in HOLD -> outputs constant, in_ready=0, no accepts. out_ready high -> IDLE next cycle, in_ready=1.
REQ-038 Two beats pos=0xFF, then rst, then one beat pos=0x3 last -> out_sum=2.
REQ-039 Single beat pos=0x7, neg=0x1, last -> out_sum=2 with POPCNT_TRUNC_LSB_EN, out_sum=2 without. pos=0x7, neg=0 -> out_sum=2 with the macro, 3 without.
